// File: rtl/bcd_counter_pkg.sv
// Shared BCD types, digit limits and the binary-to-BCD conversion used for
// load and wrap values.
package bcd_counter_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT  = 4'd9;
    localparam bcd_digit_t BCD_MIN_DIGIT  = 4'd0;
    localparam int         BCD_MAX_DIGITS = 8;
    localparam int         BCD_MAX_W      = BCD_MAX_DIGITS * 4;

    // Converts value into packed BCD, least significant digit in bits [3:0].
    // Only the low 'digits' digits are filled; the rest stay zero.
    function automatic logic [BCD_MAX_W-1:0] bin_to_bcd(input logic [31:0] value,
                                                         input int digits);
        logic [BCD_MAX_W-1:0] result;
        logic [31:0]          rem;
        logic [31:0]          dig;
        result = '0;
        rem    = value;
        for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
            if (i < digits) begin
                dig              = rem % 32'd10;
                result[i*4 +: 4] = dig[3:0];
                rem              = rem / 32'd10;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// Combinational single BCD digit cell: +1 with carry out, -1 with borrow out.
// Chained by the counter top so that carry/borrow ripple upward.
module bcd_digit
    import bcd_counter_pkg::*;
(
    input  logic [3:0] digit_in,
    input  logic       up,
    input  logic       down,
    output logic [3:0] digit_out,
    output logic       carry,
    output logic       borrow
);

    always_comb begin
        digit_out = digit_in;
        carry     = 1'b0;
        borrow    = 1'b0;
        if (up && !down) begin
            if (digit_in == BCD_MAX_DIGIT) begin
                digit_out = BCD_MIN_DIGIT;
                carry     = 1'b1;
            end else begin
                digit_out = digit_in + 4'd1;
            end
        end else if (down && !up) begin
            if (digit_in == BCD_MIN_DIGIT) begin
                digit_out = BCD_MAX_DIGIT;
                borrow    = 1'b1;
            end else begin
                digit_out = digit_in - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// Up/down counter with programmable ceiling, saturate/wrap mode, parallel load,
// and a BCD shadow count kept in step through a ripple chain of digit cells.
module bcd_updown_counter
    import bcd_counter_pkg::*;
#(
    parameter int DIGITS    = 2,
    parameter int MAX_COUNT = 25,
    parameter int BW        = $clog2(MAX_COUNT + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inc,
    input  logic                  dec,
    input  logic                  wrap_en,
    input  logic                  load,
    input  logic [BW-1:0]         load_val,
    output logic [BW-1:0]         count,
    output logic [DIGITS*4-1:0]   bcd,
    output logic                  at_max,
    output logic                  at_min,
    output logic                  ovf,
    output logic                  unf
);

    localparam int                BCD_W   = DIGITS * 4;
    localparam logic [BW-1:0]     MAX_CNT = BW'(MAX_COUNT);
    localparam logic [BCD_W-1:0]  MAX_BCD = BCD_W'(bin_to_bcd(32'(MAX_COUNT), DIGITS));

    logic [BW-1:0]    count_q, count_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             at_max_q, at_max_d;
    logic             at_min_q, at_min_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             do_inc, do_dec;
    logic [BW-1:0]    load_clamped;
    logic [BCD_W-1:0] bcd_step;
    logic [DIGITS:0]  up_chain, down_chain;
    logic             chain_unused;

    assign do_inc = inc & ~dec;
    assign do_dec = dec & ~inc;

    // The registered boundary flags gate the chain, so it only ever steps
    // strictly inside [0, MAX_COUNT]; wrap is handled by direct assignment.
    assign up_chain[0]   = do_inc & ~at_max_q;
    assign down_chain[0] = do_dec & ~at_min_q;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit u_digit (
                .digit_in  (bcd_q[gi*4 +: 4]),
                .up        (up_chain[gi]),
                .down      (down_chain[gi]),
                .digit_out (bcd_step[gi*4 +: 4]),
                .carry     (up_chain[gi+1]),
                .borrow    (down_chain[gi+1])
            );
        end
    endgenerate

    assign chain_unused = up_chain[DIGITS] | down_chain[DIGITS];

    assign load_clamped = (load_val > MAX_CNT) ? MAX_CNT : load_val;

    always_comb begin
        count_d = count_q;
        bcd_d   = bcd_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (load) begin
            count_d = load_clamped;
            bcd_d   = BCD_W'(bin_to_bcd(32'(load_clamped), DIGITS));
        end else if (do_inc) begin
            if (at_max_q) begin
                ovf_d = 1'b1;
                if (wrap_en) begin
                    count_d = '0;
                    bcd_d   = '0;
                end
            end else begin
                count_d = count_q + BW'(1);
                bcd_d   = bcd_step;
            end
        end else if (do_dec) begin
            if (at_min_q) begin
                unf_d = 1'b1;
                if (wrap_en) begin
                    count_d = MAX_CNT;
                    bcd_d   = MAX_BCD;
                end
            end else begin
                count_d = count_q - BW'(1);
                bcd_d   = bcd_step;
            end
        end
        at_max_d = (count_d == MAX_CNT);
        at_min_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q  <= '0;
            bcd_q    <= '0;
            at_max_q <= 1'b0;
            at_min_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            bcd_q    <= bcd_d;
            at_max_q <= at_max_d;
            at_min_q <= at_min_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign count  = count_q;
    assign bcd    = bcd_q;
    assign at_max = at_max_q;
    assign at_min = at_min_q;
    assign ovf    = ovf_q;
    assign unf    = unf_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed and randomised checks of bcd_updown_counter with DIGITS=2, MAX_COUNT=25.
module tb_bcd_updown_counter;

    localparam int DIGITS = 2;
    localparam int MAXC   = 25;
    localparam int BW     = 5;

    logic          clk;
    logic          reset;
    logic          inc, dec, wrap_en, load;
    logic [BW-1:0] load_val;
    logic [BW-1:0] count;
    logic [7:0]    bcd;
    logic          at_max, at_min, ovf, unf;
    logic [16:0]   obs;

    int checks = 0;
    int errors = 0;

    bcd_updown_counter #(.DIGITS(DIGITS), .MAX_COUNT(MAXC)) dut (
        .clk      (clk),
        .reset    (reset),
        .inc      (inc),
        .dec      (dec),
        .wrap_en  (wrap_en),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .bcd      (bcd),
        .at_max   (at_max),
        .at_min   (at_min),
        .ovf      (ovf),
        .unf      (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {count, bcd, at_max, at_min, ovf, unf};

    // Expected {count, bcd, at_max, at_min, ovf, unf} for a given count and pulses.
    function automatic logic [16:0] exp_vec(input int c, input logic o, input logic u);
        logic [3:0] d0, d1;
        d0 = 4'(c % 10);
        d1 = 4'((c / 10) % 10);
        return {5'(c), d1, d0, (c == MAXC), (c == 0), o, u};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inc = 0; dec = 0; load = 0;
    endtask

    task automatic test_reset();
        logic [16:0] e;
        reset = 0; inc = 1; dec = 0; load = 0; wrap_en = 0; load_val = '0;
        for (int i = 0; i < 2; i++) begin
            step();
            e = exp_vec(0, 0, 0);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %h expected %h", i, obs, e);
            end else $display("reset_hold[%0d] ok state=%h", i, obs);
        end
        reset = 1;
        for (int i = 1; i <= 10; i++) begin
            step();
            e = exp_vec(i, 0, 0);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL inc_run[%0d]: got %h expected %h", i, obs, e);
            end else $display("inc_run[%0d] ok count=%0d bcd=%h", i, count, bcd);
        end
        checks++;
        if (count !== 5'd10 || bcd !== 8'h10) begin
            errors++;
            $display("FAIL digit_carry: got count=%0d bcd=%h expected count=10 bcd=10", count, bcd);
        end else $display("digit_carry ok bcd=%h", bcd);
        idle();
    endtask

    task automatic test_saturate();
        int          exp_c[5] = '{24, 25, 25, 25, 25};
        logic        exp_o[5] = '{0, 0, 1, 1, 0};
        logic [16:0] e;
        wrap_en = 0;
        for (int i = 0; i < 5; i++) begin
            load = (i == 0); load_val = 5'd24;
            inc  = (i >= 1 && i <= 3);
            step();
            e = exp_vec(exp_c[i], exp_o[i], 0);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL saturate[%0d]: got %h expected %h", i, obs, e);
            end else $display("saturate[%0d] ok count=%0d ovf=%b", i, count, ovf);
        end
        idle();
    endtask

    task automatic test_wrap();
        int          exp_c[3] = '{0, 25, 25};
        logic        exp_o[3] = '{1, 0, 0};
        logic        exp_u[3] = '{0, 1, 0};
        logic [16:0] e;
        wrap_en = 1;
        for (int i = 0; i < 3; i++) begin
            inc = (i == 0); dec = (i == 1); load = 0;
            step();
            e = exp_vec(exp_c[i], exp_o[i], exp_u[i]);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL wrap[%0d]: got %h expected %h", i, obs, e);
            end else $display("wrap[%0d] ok count=%0d ovf=%b unf=%b", i, count, ovf, unf);
        end
        idle();
    endtask

    task automatic test_load();
        logic [4:0]  vals[3]  = '{5'd31, 5'd7, 5'd3};
        logic        lds[3]   = '{1, 1, 0};
        logic        incs[3]  = '{0, 1, 0};
        int          exp_c[3] = '{25, 7, 7};
        logic [16:0] e;
        wrap_en = 0;
        for (int i = 0; i < 3; i++) begin
            load = lds[i]; load_val = vals[i]; inc = incs[i]; dec = 0;
            step();
            e = exp_vec(exp_c[i], 0, 0);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL load[%0d]: got %h expected %h", i, obs, e);
            end else $display("load[%0d] ok count=%0d", i, count);
        end
        idle();
    endtask

    task automatic test_hold_borrow();
        logic [16:0] e;
        wrap_en = 0;
        load = 1; load_val = 5'd10;
        step();
        load = 0; inc = 1; dec = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            e = exp_vec(10, 0, 0);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL hold[%0d]: got %h expected %h", i, obs, e);
            end else $display("hold[%0d] ok count=%0d", i, count);
        end
        inc = 0;
        step();
        checks++;
        if (count !== 5'd9 || bcd !== 8'h09 || unf !== 1'b0) begin
            errors++;
            $display("FAIL digit_borrow: got count=%0d bcd=%h unf=%b expected count=9 bcd=09 unf=0", count, bcd, unf);
        end else $display("digit_borrow ok bcd=%h", bcd);
        dec = 0; load = 1; load_val = 5'd0;
        step();
        load = 0; dec = 1;
        step();
        e = exp_vec(0, 0, 1);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL floor_saturate: got %h expected %h", obs, e);
        end else $display("floor_saturate ok count=%0d unf=%b", count, unf);
        idle();
    endtask

    task automatic test_back_to_back();
        logic [16:0] e;
        load = 1; load_val = 5'd19;
        step();
        load = 0; inc = 1;
        step();
        e = exp_vec(20, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL b2b_carry: got %h expected %h", obs, e);
        end else $display("b2b_carry ok bcd=%h", bcd);
        reset = 0; load = 1; load_val = 5'd12;
        step();
        e = exp_vec(0, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL mid_reset: got %h expected %h", obs, e);
        end else $display("mid_reset ok count=%0d", count);
        reset = 1;
        idle();
    endtask

    task automatic test_random();
        int          m;
        logic        mo, mu;
        logic [16:0] e;
        int          lv;
        m = count; mo = 0; mu = 0;
        for (int n = 0; n < 5000; n++) begin
            reset    = ($urandom_range(63) != 0);
            load     = ($urandom_range(7) == 0);
            inc      = $urandom_range(1);
            dec      = $urandom_range(1);
            if ($urandom_range(15) == 0) wrap_en = ~wrap_en;
            lv       = $urandom_range(31);
            load_val = 5'(lv);
            mo = 0; mu = 0;
            if (!reset) begin
                m = 0;
            end else if (load) begin
                m = (lv > MAXC) ? MAXC : lv;
            end else if (inc && !dec) begin
                if (m == MAXC) begin
                    mo = 1;
                    if (wrap_en) m = 0;
                end else m = m + 1;
            end else if (dec && !inc) begin
                if (m == 0) begin
                    mu = 1;
                    if (wrap_en) m = MAXC;
                end else m = m - 1;
            end
            step();
            e = exp_vec(m, mo, mu);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL random[%0d]: got %h expected %h", n, obs, e);
            end else $display("random[%0d] ok count=%0d bcd=%h", n, count, bcd);
        end
        idle();
        reset = 1;
    endtask

    initial begin
        test_reset();
        test_saturate();
        test_wrap();
        test_load();
        test_hold_borrow();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
